// File: rtl/seq_det_arbiter.sv
// Round-robin time-shared "1101" overlapping detector over NCH serial channels.
// Define SEQ_DET_ARB_MATCH_CNT_EN to add per-channel saturating match counters.
module seq_det_arbiter #(
    parameter int unsigned     NCH     = 4,
    parameter int unsigned     PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1101,
    parameter int unsigned     CHW     = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] din_vld,
    input  logic [NCH-1:0] din,
    output logic [NCH-1:0] din_rdy,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] ch_clr,
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    input  logic [CHW-1:0] cnt_sel,
    output logic [7:0]     cnt_out,
`endif
    output logic           dout,
    output logic [CHW-1:0] dout_ch
);

    localparam int unsigned FW = $clog2(PLEN + 1);

    logic [PLEN-1:0] hist_q [NCH];
    logic [PLEN-1:0] hist_d [NCH];
    logic [FW-1:0]   fill_q [NCH];
    logic [FW-1:0]   fill_d [NCH];
    logic [CHW-1:0]  last_q, last_d;
    logic            dout_q, dout_d;
    logic [CHW-1:0]  dout_ch_q, dout_ch_d;
    logic [NCH-1:0]  elig;
    logic [NCH-1:0]  grant;
    logic [PLEN-1:0] hist_nxt;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    logic [7:0]      cnt_q [NCH];
    logic [7:0]      cnt_d [NCH];
`endif

    // Two passes: channels above last_q first, then wrap to those at or below it.
    always_comb begin
        elig  = din_vld & ch_en & ~ch_clr;
        grant = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (grant == '0 && elig[i] && i > 32'(last_q)) begin
                    grant[i] = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (grant == '0 && elig[i] && i <= 32'(last_q)) begin
                    grant[i] = 1'b1;
                end
            end
        end
    end

    assign din_rdy = grant;

    always_comb begin
        dout_d    = 1'b0;
        dout_ch_d = dout_ch_q;
        last_d    = last_q;
        hist_nxt  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hist_d[i] = hist_q[i];
            fill_d[i] = fill_q[i];
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
            cnt_d[i]  = cnt_q[i];
`endif
            if (ch_clr[i]) begin
                hist_d[i] = '0;
                fill_d[i] = '0;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
                cnt_d[i]  = '0;
`endif
            end else if (grant[i]) begin
                hist_nxt  = {hist_q[i][PLEN-2:0], din[i]};
                hist_d[i] = hist_nxt;
                fill_d[i] = (fill_q[i] == FW'(PLEN)) ? fill_q[i] : fill_q[i] + FW'(1);
                last_d    = CHW'(i);
                if (hist_nxt == PATTERN && fill_d[i] == FW'(PLEN)) begin
                    dout_d    = 1'b1;
                    dout_ch_d = CHW'(i);
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
                    if (cnt_q[i] != 8'hFF) begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
                cnt_q[i]  <= '0;
`endif
            end
            last_q    <= CHW'(NCH - 1);
            dout_q    <= 1'b0;
            dout_ch_q <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
            cnt_q     <= cnt_d;
`endif
            last_q    <= last_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
        end
    end

    assign dout    = dout_q;
    assign dout_ch = dout_ch_q;

`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    always_comb begin
        cnt_out = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (CHW'(i) == cnt_sel) begin
                cnt_out = cnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed self-checking bench for seq_det_arbiter (NCH=4, PATTERN=1101).
module tb_seq_det_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din_vld = '0;
    logic [3:0] din = '0;
    logic [3:0] din_rdy;
    logic [3:0] ch_en = 4'hF;
    logic [3:0] ch_clr = '0;
    logic       dout;
    logic [1:0] dout_ch;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    logic [1:0] cnt_sel = '0;
    logic [7:0] cnt_out;
`endif

    int checks = 0;
    int failures = 0;
    int pulses;

    always #5 clk = ~clk;

    seq_det_arbiter #(
        .NCH(4),
        .PLEN(4),
        .PATTERN(4'b1101),
        .CHW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din_vld(din_vld),
        .din(din),
        .din_rdy(din_rdy),
        .ch_en(ch_en),
        .ch_clr(ch_clr),
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
        .cnt_sel(cnt_sel),
        .cnt_out(cnt_out),
`endif
        .dout(dout),
        .dout_ch(dout_ch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check the combinational grant, then the registered result.
    task automatic cyc(input string tag, input logic [3:0] vld, input logic [3:0] d,
                       input logic [3:0] en, input logic [3:0] clr, input logic [3:0] exp_rdy,
                       input logic exp_dout, input logic [1:0] exp_ch);
        din_vld = vld;
        din     = d;
        ch_en   = en;
        ch_clr  = clr;
        #1;
        check({tag, ":rdy"}, 32'(din_rdy), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check({tag, ":dout"}, 32'(dout), 32'(exp_dout));
        if (exp_dout) check({tag, ":ch"}, 32'(dout_ch), 32'(exp_ch));
        pulses += int'(dout);
        din_vld = '0;
        ch_clr  = '0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        din_vld = '0;
        ch_clr  = '0;
        ch_en   = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] s1;
        logic [3:0] s2;
        logic       b;

        // Reset state; grants suppressed while rst is high.
        din_vld = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst:rdy", 32'(din_rdy), 32'h0);
        check("rst:dout", 32'(dout), 32'h0);
        check("rst:ch", 32'(dout_ch), 32'h0);
        do_reset();

        // Overlapping pattern on ch0: 1101101 gives two detections.
        s1 = 7'b1101101;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            b = s1[6 - k];
            cyc("t1", 4'b0001, {3'b000, b}, 4'hF, 4'h0, 4'b0001, (k == 3 || k == 6), 2'd0);
        end
        check("t1:pulses", 32'(pulses), 32'd2);
        cyc("t1:idle", 4'b0000, 4'b0000, 4'hF, 4'h0, 4'b0000, 1'b0, 2'd0);

        // Ch0 and ch1 alternate; back-to-back detections on ch0 then ch1.
        do_reset();
        s2 = 4'b1101;
        for (int k = 0; k < 8; k++) begin
            b = s2[3 - k / 2];
            cyc("t2", 4'b0011, {2'b00, b, b}, 4'hF, 4'h0, (k % 2 == 1) ? 4'b0010 : 4'b0001,
                (k >= 6), 2'(k % 2));
        end
        cyc("t2:idle", 4'b0000, 4'b0000, 4'hF, 4'h0, 4'b0000, 1'b0, 2'd0);

        // Ch2 paused by ch_en mid-pattern keeps its context.
        do_reset();
        pulses = 0;
        cyc("t3:a", 4'b0100, 4'b0100, 4'hF, 4'h0, 4'b0100, 1'b0, 2'd0);
        cyc("t3:b", 4'b0100, 4'b0100, 4'hF, 4'h0, 4'b0100, 1'b0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            cyc("t3:off", 4'b0100, 4'b0100, 4'b1011, 4'h0, 4'b0000, 1'b0, 2'd0);
        end
        cyc("t3:c", 4'b0100, 4'b0000, 4'hF, 4'h0, 4'b0100, 1'b0, 2'd0);
        cyc("t3:d", 4'b0100, 4'b0100, 4'hF, 4'h0, 4'b0100, 1'b1, 2'd2);
        check("t3:pulses", 32'(pulses), 32'd1);

        // ch_clr blocks the grant and drops the partial pattern.
        do_reset();
        cyc("t4:a", 4'b0010, 4'b0010, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd0);
        cyc("t4:b", 4'b0010, 4'b0010, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd0);
        cyc("t4:c", 4'b0010, 4'b0000, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd0);
        cyc("t4:clr", 4'b0010, 4'b0010, 4'hF, 4'b0010, 4'b0000, 1'b0, 2'd0);
        cyc("t4:d", 4'b0010, 4'b0010, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd0);
        cyc("t4:e", 4'b0010, 4'b0010, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd0);
        cyc("t4:f", 4'b0010, 4'b0000, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd0);
        cyc("t4:g", 4'b0010, 4'b0010, 4'hF, 4'h0, 4'b0010, 1'b1, 2'd1);

        // Reset mid-stream on ch0: offered bit not taken, context lost.
        do_reset();
        cyc("t5:a", 4'b0001, 4'b0001, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("t5:b", 4'b0001, 4'b0001, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("t5:c", 4'b0001, 4'b0000, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        rst     = 1'b1;
        din_vld = 4'b0001;
        din     = 4'b0001;
        #1;
        check("t5:rst_rdy", 32'(din_rdy), 32'h0);
        @(posedge clk);
        #1;
        check("t5:rst_dout", 32'(dout), 32'h0);
        rst = 1'b0;
        cyc("t5:d", 4'b0001, 4'b0001, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("t5:e", 4'b0001, 4'b0001, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("t5:f", 4'b0001, 4'b0001, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("t5:g", 4'b0001, 4'b0000, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("t5:h", 4'b0001, 4'b0001, 4'hF, 4'h0, 4'b0001, 1'b1, 2'd0);

        // Round-robin wrap with all four requesting, then with ch1 disabled.
        do_reset();
        cyc("rr:0", 4'hF, 4'h0, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("rr:1", 4'hF, 4'h0, 4'hF, 4'h0, 4'b0010, 1'b0, 2'd0);
        cyc("rr:2", 4'hF, 4'h0, 4'hF, 4'h0, 4'b0100, 1'b0, 2'd0);
        cyc("rr:3", 4'hF, 4'h0, 4'hF, 4'h0, 4'b1000, 1'b0, 2'd0);
        cyc("rr:4", 4'hF, 4'h0, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0);
        cyc("rr:5", 4'hF, 4'h0, 4'b1101, 4'h0, 4'b0100, 1'b0, 2'd0);
        cyc("rr:6", 4'hF, 4'h0, 4'b1101, 4'h0, 4'b1000, 1'b0, 2'd0);
        cyc("rr:7", 4'hF, 4'h0, 4'b1101, 4'h0, 4'b0001, 1'b0, 2'd0);

`ifdef SEQ_DET_ARB_MATCH_CNT_EN
        // 300 "1101" blocks on ch3: counter saturates at 255.
        do_reset();
        pulses = 0;
        s2 = 4'b1101;
        for (int r = 0; r < 300; r++) begin
            for (int k = 0; k < 4; k++) begin
                din_vld = 4'b1000;
                din     = {s2[3 - k], 3'b000};
                @(posedge clk);
                #1;
                pulses += int'(dout);
            end
        end
        din_vld = '0;
        check("cnt:pulses", 32'(pulses), 32'd300);
        cnt_sel = 2'd3;
        #1;
        check("cnt:ch3", 32'(cnt_out), 32'd255);
        cnt_sel = 2'd0;
        #1;
        check("cnt:ch0", 32'(cnt_out), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
- Time-shares one Moore-style overlapping serial pattern detector ("1101" by default) among NCH independent serial input channels.
- Round-robin arbiter accepts at most one bit per cycle from one channel and updates that channel's saved detector context (bit history and fill count).
- Reports each detection as a registered one-cycle pulse tagged with the channel ID.
- Sits between per-channel serial sources and downstream event logic.

Parameters:
- NCH, 4, number of requesting serial channels (2..8)
- PLEN, 4, pattern length in bits (2..8)
- PATTERN, 4'b1101, pattern to detect; MSB is the first bit received
- CHW, 2, channel ID width; must satisfy 2**CHW >= NCH

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- din_vld  in  NCH  per-channel bit-valid request
- din  in  NCH  per-channel serial data bit
- din_rdy  out  NCH  one-hot grant, combinational; bit consumed when din_vld[i] & din_rdy[i]
- ch_en  in  NCH  per-channel enable; disabled channel never granted
- ch_clr  in  NCH  per-channel context clear, one-cycle pulse
- dout  out  1  detection pulse, registered
- dout_ch  out  CHW  channel ID of the current detection; valid only while dout=1

Behaviour:
- Reset (sync, rst=1 at posedge):
  - all histories = 0, all fill counts = 0, dout = 0, dout_ch = 0
  - last_grant = NCH-1, so channel 0 has first priority
  - din_rdy = 0 while rst is high
- Arbitration:
  - Eligible channel i: din_vld[i] & ch_en[i] & ~ch_clr[i].
  - Search starts at last_grant+1 (mod NCH), wraps around; first eligible channel is granted.
  - At most one din_rdy bit high per cycle. No eligible channel -> din_rdy = 0, last_grant unchanged.
  - last_grant updates to the granted index only on an accepted bit.
- Context per channel:
  - hist[i], PLEN bits.
  - fill[i], saturating count 0..PLEN.
- On accept from channel g:
  - hist[g] <= {hist[g][PLEN-2:0], din[g]}
  - fill[g] <= min(fill[g]+1, PLEN)
  - Other channels' contexts are untouched.
- Detection (Moore, overlapping):
  - Condition: new hist == PATTERN and new fill == PLEN.
  - Result: dout = 1 and dout_ch = g in the cycle after the accept edge.
  - Latency: accept edge -> dout high for exactly one cycle.
  - Overlap is preserved per channel, e.g. 1101101 yields 2 detections.
- dout is 0 in every cycle that did not follow a qualifying accept.
- Back-to-back detections on different channels in consecutive cycles are legal and give consecutive dout pulses with different dout_ch.
- ch_clr[i]:
  - At the edge: hist[i] <= 0, fill[i] <= 0.
  - Channel i is not granted in that cycle, so clear wins over any pending bit.
  - Other channels are unaffected.
- ch_en[i] deasserted mid-stream: context is retained; bits resume from the saved state when re-enabled.
- Reset mid-operation: the bit offered in the reset cycle is not consumed; all contexts clear.
- Partial pattern split across non-consecutive grants is still detected, because context is per channel.

Optional Feature:
- Macro: SEQ_DET_ARB_MATCH_CNT_EN
- Defined:
  - Adds per-channel 8-bit saturating match counters, cleared by rst or ch_clr[i].
  - Each counter increments on the same edge that sets dout for that channel and saturates at 255.
  - Adds ports cnt_sel (in, CHW) and cnt_out (out, 8). cnt_out = counter[cnt_sel], combinational read.
- Undefined: no counters and no cnt_sel/cnt_out ports; all other behaviour identical.

Test Plan:
- Single channel 0 only, bits 1,1,0,1,1,0,1 on consecutive cycles -> dout pulses after the 4th and 7th accepts, dout_ch=0, 2 pulses total.
- Channels 0 and 1 both always valid -> din_rdy alternates 0001, 0010, 0001, ...; ch0 stream 1101 and ch1 stream 1101 -> detections on ch0 then ch1 in consecutive cycles.
- Ch2 sends 1,1 then ch_en[2]=0 for 5 cycles, then 0,1 -> exactly 1 detection, dout_ch=2.
- Ch1 sends 1,1,0, then ch_clr[1] pulse with din_vld[1]=1 -> no grant that cycle; then 1 -> no detection, because fill was reset.
- rst asserted after ch0 receives 1,1,0; then ch0 sends 1 -> no detection; 1,1,0,1 after that -> 1 detection.
- With SEQ_DET_ARB_MATCH_CNT_EN: 300 back-to-back "1101" repeats on ch3 -> cnt_out with cnt_sel=3 reads 255; cnt_sel=0 reads 0.
